readout_scheduler: RTL and testbench

READOUT_SCHEDULER -- requirements
Module: readout_scheduler

---
 rtl/readout_scheduler_pkg.sv | 26 ++
 rtl/readout_scheduler_slot_next_finder.sv | 37 +++
 rtl/readout_scheduler.sv | 179 +++++++++++++++++
 tb/tb_readout_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_scheduler_pkg.sv
// ============================================================================
// readout_scheduler_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the readout scheduler:
//   - state_t      : scheduler state encoding
//   - HDR_LEN      : number of frame-header bits
//   - HDR_PATTERN  : frame-header bit pattern, sent MSB first
//   - DEFAULT_*    : default slot count and word width
// ============================================================================
package readout_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HEADER = 3'd1,
        LOAD   = 3'd2,
        SHIFT  = 3'd3,
        CLEAR  = 3'd4
    } state_t;

    localparam int             HDR_LEN        = 4;
    localparam logic [HDR_LEN-1:0] HDR_PATTERN = 4'b1010;

    localparam int DEFAULT_N_SLOT = 16;
    localparam int DEFAULT_WORD_W = 12;

endpackage : readout_scheduler_pkg

// File: rtl/readout_scheduler_slot_next_finder.sv
// ============================================================================
// slot_next_finder
// ----------------------------------------------------------------------------
// Combinational search for the lowest enabled slot strictly above the
// current one.
//
// Ports:
//   mask       in   N_SLOT  per-slot enable (latched frame copy)
//   cur        in   SEL_W   slot currently being read
//   next_slot  out  SEL_W   lowest enabled slot above cur (0 when none)
//   none       out  1       no enabled slot remains above cur
// ============================================================================
module slot_next_finder
    import readout_scheduler_pkg::*;
#(
    parameter int N_SLOT = DEFAULT_N_SLOT,
    parameter int SEL_W  = 4
) (
    input  logic [N_SLOT-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_slot,
    output logic              none
);

    // Scan from the top down so the lowest qualifying slot is the last write.
    always_comb begin
        next_slot = '0;
        none      = 1'b1;
        for (int i = N_SLOT - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                next_slot = SEL_W'(i);
                none      = 1'b0;
            end
        end
    end

endmodule : slot_next_finder

// File: rtl/readout_scheduler.sv
// ============================================================================
// readout_scheduler
// ----------------------------------------------------------------------------
// Frame scheduler for a multiplexed counter readout. A rising edge on trig
// (registered) starts a frame: slot 0 (RTC word) and every enabled channel
// slot is parallel-loaded into an external shift register (sl) and then
// shifted out for WORD_W cycles (shift_en). After the last enabled slot the
// counters are cleared with a one-cycle clr pulse.
//
// Optional feature macro: SCHED_HEADER_EN
//   When defined, a 4-cycle serial header (hdr_bit = 1,0,1,0 with hdr_active)
//   precedes the first slot load. When undefined, hdr_active/hdr_bit are 0.
//
// Ports:
//   clk         in   1       clock, rising edge
//   reset       in   1       synchronous, active-low reset
//   trig        in   1       readout request level
//   ch_mask     in   N_SLOT  per-slot read enable (bit 0 always read)
//   sel         out  SEL_W   mux select of the current slot
//   sl          out  1       one-cycle parallel-load strobe
//   shift_en    out  1       high while a word is shifting
//   clr         out  1       one-cycle counter clear at frame end
//   busy        out  1       high from frame start through the clr cycle
//   missed      out  1       sticky: trigger edge arrived while busy
//   hdr_active  out  1       header stream valid
//   hdr_bit     out  1       header serial bit
// ============================================================================
module readout_scheduler
    import readout_scheduler_pkg::*;
#(
    parameter int N_SLOT = DEFAULT_N_SLOT,
    parameter int WORD_W = DEFAULT_WORD_W,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [N_SLOT-1:0] ch_mask,
    output logic [SEL_W-1:0]  sel,
    output logic              sl,
    output logic              shift_en,
    output logic              clr,
    output logic              busy,
    output logic              missed,
    output logic              hdr_active,
    output logic              hdr_bit
);

    localparam int               CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_t            state;
    logic              trig_q;
    logic              trig_prev;
    logic              trig_edge;
    logic [N_SLOT-1:0] mask_q;
    logic [CNT_W-1:0]  bit_cnt;
    logic [SEL_W-1:0]  next_slot;
    logic              no_next;

    // Edge on the registered copy only, so a held-high trig fires once.
    assign trig_edge = trig_q & ~trig_prev;

    slot_next_finder #(
        .N_SLOT (N_SLOT),
        .SEL_W  (SEL_W)
    ) u_finder (
        .mask      (mask_q),
        .cur       (sel),
        .next_slot (next_slot),
        .none      (no_next)
    );

`ifdef SCHED_HEADER_EN
    logic [1:0] hdr_cnt;
`else
    assign hdr_active = 1'b0;
    assign hdr_bit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            trig_q    <= 1'b0;
            trig_prev <= 1'b0;
            mask_q    <= '0;
            bit_cnt   <= '0;
            sel       <= '0;
            sl        <= 1'b0;
            shift_en  <= 1'b0;
            clr       <= 1'b0;
            busy      <= 1'b0;
            missed    <= 1'b0;
`ifdef SCHED_HEADER_EN
            hdr_cnt    <= '0;
            hdr_active <= 1'b0;
            hdr_bit    <= 1'b0;
`endif
        end else begin
            trig_q    <= trig;
            trig_prev <= trig_q;
            sl        <= 1'b0;
            clr       <= 1'b0;

            // Any edge outside IDLE (including the CLEAR cycle) is lost.
            if (trig_edge && (state != IDLE)) begin
                missed <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trig_edge) begin
                        // Slot 0 carries the RTC word and is always read.
                        mask_q <= ch_mask | N_SLOT'(1);
                        busy   <= 1'b1;
                        sel    <= '0;
`ifdef SCHED_HEADER_EN
                        state      <= HEADER;
                        hdr_cnt    <= '0;
                        hdr_active <= 1'b1;
                        hdr_bit    <= HDR_PATTERN[HDR_LEN-1];
`else
                        state <= LOAD;
                        sl    <= 1'b1;
`endif
                    end
                end

`ifdef SCHED_HEADER_EN
                HEADER: begin
                    if (hdr_cnt == 2'(HDR_LEN - 1)) begin
                        hdr_active <= 1'b0;
                        hdr_bit    <= 1'b0;
                        state      <= LOAD;
                        sl         <= 1'b1;
                    end else begin
                        hdr_cnt <= hdr_cnt + 2'd1;
                        hdr_bit <= HDR_PATTERN[2'(HDR_LEN - 2) - hdr_cnt];
                    end
                end
`endif

                LOAD: begin
                    state    <= SHIFT;
                    shift_en <= 1'b1;
                    bit_cnt  <= '0;
                end

                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        shift_en <= 1'b0;
                        if (no_next) begin
                            state <= CLEAR;
                            clr   <= 1'b1;
                        end else begin
                            // Disabled slots are jumped over with no idle cycles.
                            state <= LOAD;
                            sl    <= 1'b1;
                            sel   <= next_slot;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                CLEAR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sel   <= '0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : readout_scheduler

// File: tb/tb_readout_scheduler.sv
// ============================================================================
// tb_readout_scheduler
// ----------------------------------------------------------------------------
// Scoreboard bench for readout_scheduler (default parameters). Each frame
// request pushes its expected sl/clr events (slot and cycle) plus the
// expected busy and shift_en run lengths; a negedge monitor pops and
// compares them as the DUT produces them.
// ============================================================================
`timescale 1ns/1ps
module tb_readout_scheduler;

    typedef struct {
        bit is_clr;
        int sel;
        int cyc;
    } ev_t;

`ifdef SCHED_HEADER_EN
    localparam int HDR = 4;
`else
    localparam int HDR = 0;
`endif
    localparam logic [3:0] PAT = 4'b1010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trig = 1'b0;
    logic [15:0] ch_mask = '0;
    logic [3:0]  sel;
    logic        sl, shift_en, clr, busy, missed, hdr_active, hdr_bit;

    int  cyc = 0;
    int  tests = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;
    ev_t exp_q[$];
    int  busy_q[$];
    int  shift_q[$];

    readout_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .ch_mask    (ch_mask),
        .sel        (sel),
        .sl         (sl),
        .shift_en   (shift_en),
        .clr        (clr),
        .busy       (busy),
        .missed     (missed),
        .hdr_active (hdr_active),
        .hdr_bit    (hdr_bit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT emits sl, clr or
    // finishes a busy window.
    int busy_run = 0;
    int shift_run = 0;
    int hdr_idx = 0;
    always @(negedge clk) begin
        if (!mon_en) begin
            busy_run  = 0;
            shift_run = 0;
            hdr_idx   = 0;
        end else begin
            ev_t e;
            if (sl) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected sl", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sl kind", 32'(e.is_clr), 0);
                    checkOutput("sl sel", 32'(sel), e.sel);
                    checkOutput("sl cycle", cyc, e.cyc);
                    checkOutput("sl shift_en low", 32'(shift_en), 0);
                end
            end
            if (clr) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected clr", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("clr kind", 32'(e.is_clr), 1);
                    checkOutput("clr cycle", cyc, e.cyc);
                end
            end
            if (busy) begin
                busy_run++;
                if (shift_en) shift_run++;
            end else if (busy_run != 0) begin
                if (busy_q.size() == 0) begin
                    checkOutput("unexpected busy", busy_run, 0);
                end else begin
                    checkOutput("busy length", busy_run, busy_q.pop_front());
                    checkOutput("shift cycles", shift_run, shift_q.pop_front());
                end
                busy_run  = 0;
                shift_run = 0;
            end
`ifdef SCHED_HEADER_EN
            if (hdr_active) begin
                if (hdr_idx < 4) checkOutput("hdr bit", 32'(hdr_bit), 32'(PAT[3 - hdr_idx]));
                hdr_idx++;
            end else if (hdr_idx != 0) begin
                checkOutput("hdr length", hdr_idx, 4);
                hdr_idx = 0;
            end
`else
            if (hdr_active || hdr_bit) checkOutput("hdr tied low", {hdr_active, hdr_bit}, 0);
`endif
        end
    end

    // mode 0: single edge; 1: second edge mid-frame; 2: trig held high
    // afterwards; 3: second edge lands in the CLEAR cycle.
    task automatic applyStimulus(input logic [15:0] mask, input int mode);
        ev_t e;
        int  k;
        int  base;
        int  n;
        @(posedge clk); #1;
        ch_mask = mask;
        trig    = 1'b1;
        base    = cyc + 2 + HDR;
        k = 0;
        for (int s = 0; s < 16; s++) begin
            if (s == 0 || mask[s]) begin
                e.is_clr = 1'b0;
                e.sel    = s;
                e.cyc    = base + 13 * k;
                exp_q.push_back(e);
                k++;
            end
        end
        e.is_clr = 1'b1;
        e.sel    = 0;
        e.cyc    = base + 13 * k;
        exp_q.push_back(e);
        busy_q.push_back(13 * k + 1 + HDR);
        shift_q.push_back(12 * k);

        repeat (3) @(posedge clk);
        #1;
        ch_mask = ~mask;
        if (mode != 2) trig = 1'b0;
        if (mode == 1) begin
            repeat (2) @(posedge clk);
            #1 trig = 1'b1;
            repeat (2) @(posedge clk);
            #1 trig = 1'b0;
        end
        if (mode == 3) begin
            // Edge detected in cycle X needs trig driven just after posedge X-1.
            n = 0;
            while (cyc < base + 13 * k - 1 && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            trig = 1'b1;
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) checkOutput("frame timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        if (mode == 2 || mode == 3) begin
            repeat (20) @(posedge clk);
            #1;
            checkOutput("no retrigger busy", 32'(busy), 0);
            trig = 1'b0;
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;

        // Reset state
        reset = 1'b0;
        trig  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset outputs",
                    {sel, sl, shift_en, clr, busy, missed, hdr_active, hdr_bit}, 0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(16'hFFFF, 0);
        checkOutput("missed after full frame", 32'(missed), 0);
        applyStimulus(16'h0000, 0);
        applyStimulus(16'h8002, 0);
        applyStimulus(16'h0104, 1);
        checkOutput("missed after mid-frame edge", 32'(missed), 1);
        applyStimulus(16'h0001, 2);
        checkOutput("missed stays sticky", 32'(missed), 1);

        // Abort during slot 5 shifting: no clr, everything back to 0.
        mon_en = 1'b0;
        @(posedge clk); #1;
        ch_mask = 16'h0030;
        trig    = 1'b1;
        n = 0;
        while (!(sel == 4'd5 && shift_en) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reach slot 5 shift", 32'(n < 200), 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        trig  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort outputs",
                    {sel, sl, shift_en, clr, busy, missed, hdr_active, hdr_bit}, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort no clr", {clr, busy}, 0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(16'h0002, 0);
        checkOutput("missed after clean frame", 32'(missed), 0);
        applyStimulus(16'h0000, 3);
        checkOutput("missed on clear-cycle edge", 32'(missed), 1);

        checkOutput("scoreboard empty", exp_q.size() + busy_q.size() + shift_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule : tb_readout_scheduler
